sysid_checker: RTL and testbench
================================

# sysid_checker

Avalon-MM master that reads the system ID peripheral's two words at boot or on request and checks them against build-time constants. Word 0 is the ID and word 1 is the generation timestamp. It sits beside the Nios II on the system interconnect and drives a board-level "image OK" indication. It also gates software start when the loaded hardware image does not match the expected build.

## Interface
Parameters:
- EXPECTED_ID, 32'd0: required value of word 0.
- EXPECTED_TIMESTAMP, 32'd1491372717: required value of word 1.
- TIMEOUT_CYCLES, 1024: maximum cycles per read, measured from the first cycle `master_read` is asserted to `master_readdatavalid`. Legal range 2..65535.
- AUTO_START, 1: when 1, one check runs automatically after reset deasserts.

Ports:
- clock  in  1  single system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request to run a check; ignored while busy
- master_address  out  1  word select: 0 = ID, 1 = timestamp
- master_read  out  1  read request
- master_waitrequest  in  1  interconnect stall
- master_readdata  in  32  read data
- master_readdatavalid  in  1  read data qualifier
- busy  out  1  check in progress
- done  out  1  one-cycle pulse when a check ends (pass, fail or timeout)
- id_match  out  1  last check: word 0 == EXPECTED_ID
- ts_match  out  1  last check: word 1 == EXPECTED_TIMESTAMP
- timeout  out  1  last check aborted on timeout
- read_id  out  32  word 0 captured by the last check
- read_ts  out  32  word 1 captured by the last check

## Operation
- State machine: IDLE, ID_REQ, ID_WAIT, TS_REQ, TS_WAIT, FINISH.
- IDLE -> ID_REQ on `start`, or on the first cycle after reset when AUTO_START=1. On this transition clear id_match, ts_match, timeout, read_id and read_ts.
- ID_REQ: drive master_read=1 and master_address=0.
  - Hold both until a cycle with master_waitrequest=0; that cycle is acceptance.
  - Then go to ID_WAIT.
- ID_WAIT: master_read=0.
  - On master_readdatavalid, capture read_id and set id_match.
  - Then go to TS_REQ.
- TS_REQ / TS_WAIT: identical to ID_REQ / ID_WAIT, but with address 1, capturing read_ts and setting ts_match.
  - Then go to FINISH.
- FINISH: pulse done for one cycle, then return to IDLE.
- Timeout counter (16 bit):
  - Cleared on entry to ID_REQ and to TS_REQ.
  - Increments every cycle in REQ and WAIT states.
  - When it reaches TIMEOUT_CYCLES-1 without readdatavalid, set timeout=1, leave both match flags 0, deassert master_read and go to FINISH.
  - An abandoned response arriving later is ignored in IDLE.
- A readdatavalid in a REQ state before acceptance is an interconnect error and is ignored.
- busy=1 in every state except IDLE.
- start while busy is ignored and not queued.
- Reset asserted mid-check:
  - Immediately return to IDLE and clear all outputs.
  - master_read drops asynchronously.
  - An auto-start check reruns after release when AUTO_START=1.

## Timing
- Reset values:
  - master_read, master_address, busy, done, id_match, ts_match and timeout are 0.
  - read_id and read_ts are 0.
- All outputs are registered. master_read is driven from state bits only.
- start sampled at cycle N gives master_read=1 at N+1.
- Acceptance is at the cycle where master_read & ~master_waitrequest. master_read deasserts the following cycle.
- readdatavalid may arrive at the earliest one cycle after acceptance.
- Read data is captured at the readdatavalid edge. id_match / ts_match are valid from the next cycle.
- With zero wait states and readdatavalid one cycle after acceptance, a start at N gives done=1 at N+6.
- done and the final status flags update in the same cycle. Status holds until the next start or reset.

## Test plan
- Zero-wait slave model returning 0 and 1491372717, start at cycle 10:
  - read at 11 with address 0 and at 13 with address 1.
  - done at 16; id_match=1, ts_match=1, timeout=0.
- Slave returns timestamp 1491372718: ts_match=0, id_match=1, read_ts=1491372718, done pulses once.
- waitrequest held for 5 cycles on each read:
  - master_read and master_address stable throughout the stall.
  - Exactly two accepted reads; correct captured values.
- Slave never returns readdatavalid for word 1, TIMEOUT_CYCLES=16:
  - timeout=1 and done pulse 16 cycles after the TS_REQ entry.
  - id_match=1, ts_match=0.
- Reset pulse while in TS_WAIT, then a late readdatavalid:
  - all outputs are 0 during reset.
  - AUTO_START rerun completes with matches=1.
  - The stale response is ignored.
- start asserted again in ID_WAIT: no extra read issued, a single done pulse.

Source files
------------

// File: rtl/sysid_checker.sv
// Reads the system ID peripheral (ID word, then timestamp word) over Avalon-MM
// and compares both against the build-time constants, flagging mismatch or timeout.
module sysid_checker #(
    parameter logic [31:0] EXPECTED_ID        = 32'd0,
    parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1491372717,
    parameter int unsigned TIMEOUT_CYCLES     = 1024,
    parameter bit          AUTO_START         = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        master_address,
    output logic        master_read,
    input  logic        master_waitrequest,
    input  logic [31:0] master_readdata,
    input  logic        master_readdatavalid,
    output logic        busy,
    output logic        done,
    output logic        id_match,
    output logic        ts_match,
    output logic        timeout,
    output logic [31:0] read_id,
    output logic [31:0] read_ts,
    output logic [2:0]  dbg_state_o
);

    // Handshake: a read is accepted in the cycle where master_read=1 and
    // master_waitrequest=0; master_read/master_address are held until then.
    // Read data is only taken in a WAIT state when master_readdatavalid=1.

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ID_REQ  = 3'd1,
        S_ID_WAIT = 3'd2,
        S_TS_REQ  = 3'd3,
        S_TS_WAIT = 3'd4,
        S_FINISH  = 3'd5
    } state_t;

    // The abort fires on the cycle whose incremented count would reach TIMEOUT_CYCLES-1.
    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 2);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        auto_q, auto_d;
    logic        to_pend_q, to_pend_d;
    logic        done_q, done_d;
    logic        id_match_q, id_match_d;
    logic        ts_match_q, ts_match_d;
    logic        timeout_q, timeout_d;
    logic [31:0] read_id_q, read_id_d;
    logic [31:0] read_ts_q, read_ts_d;

    logic accept;
    logic cnt_hit;

    assign accept  = master_read & ~master_waitrequest;
    assign cnt_hit = (cnt_q == CNT_LAST);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + 16'd1;
        auto_d     = auto_q;
        to_pend_d  = to_pend_q;
        done_d     = 1'b0;
        id_match_d = id_match_q;
        ts_match_d = ts_match_q;
        timeout_d  = timeout_q;
        read_id_d  = read_id_q;
        read_ts_d  = read_ts_q;

        case (state_q)
            S_IDLE: begin
                cnt_d = 16'd0;
                if (start || auto_q) begin
                    state_d    = S_ID_REQ;
                    auto_d     = 1'b0;
                    to_pend_d  = 1'b0;
                    id_match_d = 1'b0;
                    ts_match_d = 1'b0;
                    timeout_d  = 1'b0;
                    read_id_d  = 32'd0;
                    read_ts_d  = 32'd0;
                end
            end
            S_ID_REQ: begin
                if (cnt_hit) begin
                    state_d   = S_FINISH;
                    to_pend_d = 1'b1;
                end else if (accept) begin
                    state_d = S_ID_WAIT;
                end
            end
            S_ID_WAIT: begin
                if (master_readdatavalid) begin
                    read_id_d  = master_readdata;
                    id_match_d = (master_readdata == EXPECTED_ID);
                    state_d    = S_TS_REQ;
                    cnt_d      = 16'd0;
                end else if (cnt_hit) begin
                    state_d   = S_FINISH;
                    to_pend_d = 1'b1;
                end
            end
            S_TS_REQ: begin
                if (cnt_hit) begin
                    state_d   = S_FINISH;
                    to_pend_d = 1'b1;
                end else if (accept) begin
                    state_d = S_TS_WAIT;
                end
            end
            S_TS_WAIT: begin
                if (master_readdatavalid) begin
                    read_ts_d  = master_readdata;
                    ts_match_d = (master_readdata == EXPECTED_TIMESTAMP);
                    state_d    = S_FINISH;
                end else if (cnt_hit) begin
                    state_d   = S_FINISH;
                    to_pend_d = 1'b1;
                end
            end
            S_FINISH: begin
                // timeout is published together with done so both change in one cycle
                cnt_d     = 16'd0;
                done_d    = 1'b1;
                timeout_d = to_pend_q;
                state_d   = S_IDLE;
            end
            default: begin
                cnt_d   = 16'd0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= 16'd0;
            auto_q     <= AUTO_START;
            to_pend_q  <= 1'b0;
            done_q     <= 1'b0;
            id_match_q <= 1'b0;
            ts_match_q <= 1'b0;
            timeout_q  <= 1'b0;
            read_id_q  <= 32'd0;
            read_ts_q  <= 32'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            auto_q     <= auto_d;
            to_pend_q  <= to_pend_d;
            done_q     <= done_d;
            id_match_q <= id_match_d;
            ts_match_q <= ts_match_d;
            timeout_q  <= timeout_d;
            read_id_q  <= read_id_d;
            read_ts_q  <= read_ts_d;
        end
    end

    // Bus controls decode the state register alone, so reset drops them at once.
    assign master_read    = (state_q == S_ID_REQ) || (state_q == S_TS_REQ);
    assign master_address = (state_q == S_TS_REQ);
    assign busy           = (state_q != S_IDLE);
    assign done           = done_q;
    assign id_match       = id_match_q;
    assign ts_match       = ts_match_q;
    assign timeout        = timeout_q;
    assign read_id        = read_id_q;
    assign read_ts        = read_ts_q;
    assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_sysid_checker.sv
// Bench for sysid_checker: Avalon slave model with configurable stall/latency/drop,
// directed scenarios plus randomized checks against a cycle-count reference model.
module tb_sysid_checker;

    localparam logic [31:0] EXP_ID = 32'd0;
    localparam logic [31:0] EXP_TS = 32'd1491372717;
    localparam int          TO_CYC = 16;

    logic        clock;
    logic        reset;
    logic        start;
    logic        master_address;
    logic        master_read;
    logic        master_waitrequest;
    logic [31:0] master_readdata;
    logic        master_readdatavalid;
    logic        busy;
    logic        done;
    logic        id_match;
    logic        ts_match;
    logic        timeout;
    logic [31:0] read_id;
    logic [31:0] read_ts;
    logic [2:0]  dbg_state;

    sysid_checker #(
        .EXPECTED_ID(EXP_ID),
        .EXPECTED_TIMESTAMP(EXP_TS),
        .TIMEOUT_CYCLES(TO_CYC),
        .AUTO_START(1'b1)
    ) dut (
        .clock(clock),
        .reset(reset),
        .start(start),
        .master_address(master_address),
        .master_read(master_read),
        .master_waitrequest(master_waitrequest),
        .master_readdata(master_readdata),
        .master_readdatavalid(master_readdatavalid),
        .busy(busy),
        .done(done),
        .id_match(id_match),
        .ts_match(ts_match),
        .timeout(timeout),
        .read_id(read_id),
        .read_ts(read_ts),
        .dbg_state_o(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    int checks_total  = 0;
    int checks_passed = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_total++;
        if (got === exp) checks_passed++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // ---------------- slave model ----------------
    int          stall_n = 0;
    int          lat_id  = 1;
    int          lat_ts  = 1;
    logic [31:0] ret_id  = EXP_ID;
    logic [31:0] ret_ts  = EXP_TS;
    bit          drop_id = 1'b0;
    bit          drop_ts = 1'b0;
    bit          check_stable = 1'b0;

    int          cyc = 0;
    int          acc_cyc[$];
    logic        acc_addr[$];
    int          rd_start_cyc[$];
    logic        rd_start_addr[$];
    int          done_cyc[$];
    int          pend_due[$];
    logic [31:0] pend_data[$];

    // Runs at posedge+1: books last cycle's acceptance, then drives this cycle.
    initial begin : slave
        bit   prev_read;
        bit   prev_wait;
        logic prev_addr;
        int   req_cycles;
        prev_read = 1'b0;
        prev_wait = 1'b0;
        prev_addr = 1'b0;
        req_cycles = 0;
        master_waitrequest   = 1'b0;
        master_readdatavalid = 1'b0;
        master_readdata      = 32'd0;
        forever begin
            @(posedge clock);
            #1;
            cyc++;
            if (prev_read && !prev_wait) begin
                acc_cyc.push_back(cyc - 1);
                acc_addr.push_back(prev_addr);
                if (!(prev_addr ? drop_ts : drop_id)) begin
                    pend_due.push_back(cyc - 1 + (prev_addr ? lat_ts : lat_id));
                    pend_data.push_back(prev_addr ? ret_ts : ret_id);
                end
            end
            if (check_stable && prev_read && prev_wait) begin
                check_val("stall_read_held", master_read, 1'b1);
                check_val("stall_addr_held", master_address, prev_addr);
            end
            while (pend_due.size() > 0 && pend_due[0] < cyc) begin
                void'(pend_due.pop_front());
                void'(pend_data.pop_front());
            end
            master_readdatavalid = 1'b0;
            master_readdata      = $urandom;
            if (pend_due.size() > 0 && pend_due[0] == cyc) begin
                void'(pend_due.pop_front());
                master_readdatavalid = 1'b1;
                master_readdata      = pend_data.pop_front();
            end
            if (master_read && !(prev_read && prev_wait)) begin
                rd_start_cyc.push_back(cyc);
                rd_start_addr.push_back(master_address);
                req_cycles = 1;
            end else if (master_read) begin
                req_cycles++;
            end else begin
                req_cycles = 0;
            end
            master_waitrequest = master_read && (req_cycles <= stall_n);
            if (done) done_cyc.push_back(cyc);
            prev_read = master_read;
            prev_wait = master_waitrequest;
            prev_addr = master_address;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #2;
        end
    endtask

    task automatic pulse_start(output int n);
        start = 1'b1;
        n = cyc;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_done(input int base, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (done_cyc.size() > base) begin
                ok = 1'b1;
                break;
            end
            tick(1);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_ctrl"}, {master_read, master_address, busy, done, id_match, ts_match, timeout}, 7'd0);
        check_val({tag, "_read_id"}, read_id, 32'd0);
        check_val({tag, "_read_ts"}, read_ts, 32'd0);
    endtask

    // ---------------- scoreboard ----------------
    logic [31:0] exp_q[$];

    // Reference model: expected outcome and done latency from the read rules.
    task automatic run_case(input string tag, input int stall, input int lid, input int lts,
                            input logic [31:0] rid, input logic [31:0] rts,
                            input bit did, input bit dts, output int n);
        bit          to;
        int          exp_reads;
        int          exp_done_off;
        int          a0;
        int          d0;
        bit          ok;
        to = did || dts;
        stall_n = stall; lat_id = lid; lat_ts = lts;
        ret_id = rid; ret_ts = rts; drop_id = did; drop_ts = dts;
        exp_reads = did ? 1 : 2;
        if (did)      exp_done_off = 1 + TO_CYC;
        else if (dts) exp_done_off = 2 + stall + lid + TO_CYC;
        else          exp_done_off = 4 + 2 * stall + lid + lts;
        exp_q.push_back(did ? 32'd0 : rid);
        exp_q.push_back(to ? 32'd0 : rts);
        a0 = acc_cyc.size();
        d0 = done_cyc.size();
        pulse_start(n);
        wait_done(d0, 100, ok);
        check_val({tag, "_done_seen"}, ok, 1'b1);
        if (ok) check_val({tag, "_done_latency"}, done_cyc[d0] - n, exp_done_off);
        tick(3);
        check_val({tag, "_done_count"}, done_cyc.size() - d0, 1);
        check_val({tag, "_accepted"}, acc_cyc.size() - a0, exp_reads);
        check_val({tag, "_id_match"}, id_match, !did && (rid == EXP_ID));
        check_val({tag, "_ts_match"}, ts_match, !to && (rts == EXP_TS));
        check_val({tag, "_timeout"}, timeout, to);
        check_val({tag, "_busy"}, busy, 1'b0);
        check_val({tag, "_read_id"}, read_id, exp_q.pop_front());
        check_val({tag, "_read_ts"}, read_ts, exp_q.pop_front());
    endtask

    // ---------------- test sequence ----------------
    initial begin : main
        int n;
        int r0;
        int a0;
        int d0;
        bit ok;
        reset = 1'b1;
        start = 1'b0;
        tick(3);
        check_reset_outputs("reset_init");
        reset = 1'b0;

        // auto-start check after reset release
        wait_done(0, 60, ok);
        check_val("auto_done_seen", ok, 1'b1);
        tick(2);
        check_val("auto_flags", {id_match, ts_match, timeout}, 3'b110);
        check_val("auto_read_ts", read_ts, EXP_TS);

        // zero-wait nominal: reads at N+1 (addr 0) and N+3 (addr 1), done at N+6
        r0 = rd_start_cyc.size();
        run_case("nominal", 0, 1, 1, EXP_ID, EXP_TS, 1'b0, 1'b0, n);
        check_val("nominal_read_starts", rd_start_cyc.size() - r0, 2);
        if (rd_start_cyc.size() >= r0 + 2) begin
            check_val("nominal_rd0_cycle", rd_start_cyc[r0] - n, 1);
            check_val("nominal_rd0_addr", rd_start_addr[r0], 1'b0);
            check_val("nominal_rd1_cycle", rd_start_cyc[r0 + 1] - n, 3);
            check_val("nominal_rd1_addr", rd_start_addr[r0 + 1], 1'b1);
        end

        // timestamp mismatch
        run_case("ts_mismatch", 0, 1, 1, EXP_ID, EXP_TS + 32'd1, 1'b0, 1'b0, n);

        // five-cycle waitrequest stall on each read
        check_stable = 1'b1;
        run_case("stall5", 5, 1, 1, EXP_ID, EXP_TS, 1'b0, 1'b0, n);
        check_stable = 1'b0;

        // no response for word 1: done 16 cycles after the timestamp read begins
        r0 = rd_start_cyc.size();
        d0 = done_cyc.size();
        run_case("ts_timeout", 0, 1, 1, EXP_ID, EXP_TS, 1'b0, 1'b1, n);
        if (rd_start_cyc.size() >= r0 + 2 && done_cyc.size() > d0)
            check_val("ts_timeout_from_req", done_cyc[d0] - rd_start_cyc[r0 + 1], TO_CYC);
        else
            check_val("ts_timeout_events", rd_start_cyc.size() - r0, 2);

        // reset while in TS_WAIT; the stale response lands during the rerun's stalled ID read
        stall_n = 0; lat_id = 1; lat_ts = 6;
        ret_id = EXP_ID; ret_ts = 32'hDEAD_BEEF; drop_id = 1'b0; drop_ts = 1'b0;
        a0 = acc_cyc.size();
        d0 = done_cyc.size();
        pulse_start(n);
        tick(4);
        reset = 1'b1;
        ret_ts = EXP_TS;
        stall_n = 6;
        tick(1);
        check_reset_outputs("reset_mid");
        tick(1);
        reset = 1'b0;
        wait_done(d0, 80, ok);
        check_val("rerun_done_seen", ok, 1'b1);
        tick(3);
        check_val("rerun_done_count", done_cyc.size() - d0, 1);
        check_val("rerun_accepted", acc_cyc.size() - a0, 4);
        check_val("rerun_flags", {id_match, ts_match, timeout}, 3'b110);
        check_val("rerun_read_id", read_id, EXP_ID);
        check_val("rerun_read_ts", read_ts, EXP_TS);
        stall_n = 0; lat_ts = 1;

        // start pulsed again while in ID_WAIT is ignored
        stall_n = 0; lat_id = 3; lat_ts = 1;
        ret_id = EXP_ID; ret_ts = EXP_TS;
        a0 = acc_cyc.size();
        d0 = done_cyc.size();
        pulse_start(n);
        tick(1);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        wait_done(d0, 60, ok);
        check_val("restart_done_seen", ok, 1'b1);
        if (ok) check_val("restart_done_latency", done_cyc[d0] - n, 8);
        tick(6);
        check_val("restart_done_count", done_cyc.size() - d0, 1);
        check_val("restart_accepted", acc_cyc.size() - a0, 2);
        check_val("restart_busy", busy, 1'b0);

        // randomized checks
        for (int k = 0; k < 24; k++) begin
            int          st;
            int          li;
            int          lt;
            logic [31:0] ri;
            logic [31:0] rt;
            bit          di;
            bit          dt;
            st = $urandom_range(0, 3);
            li = $urandom_range(1, 4);
            lt = $urandom_range(1, 4);
            ri = ($urandom_range(0, 1) == 1) ? EXP_ID : $urandom;
            rt = ($urandom_range(0, 1) == 1) ? EXP_TS : $urandom;
            di = ($urandom_range(0, 7) == 0);
            dt = ($urandom_range(0, 7) == 0);
            run_case("rand", st, li, lt, ri, rt, di, dt, n);
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
